// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: walks a ROM bank from start_addr to end_addr (inclusive, wrapping),
// registering each word into a valid/ready stream with one-shot, loop and abort control.
module rom_scan_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              bank_sel,
    input  logic              loop_mode,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_bank,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              loop_en;
    logic              take;

    // The output register can accept a new word when empty or being drained this cycle.
    assign take = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            first_addr <= '0;
            last_addr  <= '0;
            loop_en    <= 1'b0;
            rom_addr   <= '0;
            rom_bank   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !abort) begin
                    first_addr <= start_addr;
                    last_addr  <= end_addr;
                    loop_en    <= loop_mode;
                    rom_addr   <= start_addr;
                    rom_bank   <= bank_sel;
                    state      <= RUN;
                    busy       <= 1'b1;
                end
            end else if (abort) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else if (state == RUN) begin
                if (take) begin
                    out_data  <= rom_data;
                    out_valid <= 1'b1;
                    if (rom_addr != last_addr)
                        rom_addr <= rom_addr + 1'b1;
                    else if (loop_en)
                        rom_addr <= first_addr;
                    else
                        state <= DRAIN;
                end
            end else if (take) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
            end
        end
    end
endmodule

// File: doc/rom_scan_ctrl.md
Name: rom_scan_ctrl

Overview:
- Sequencer that replaces the free-running enable counter in front of rom_7.
- Walks the ROM address from a programmed start to end address in a selected bank, and registers each ROM word into a valid/ready output stream.
- Supports one-shot and continuous loop scans, an abort, and stalls the address under downstream backpressure.
- Sits between the control logic that issues scan commands and any consumer of ROM data.

Parameters:
ADDR_W, 8, ROM address width; the address wraps modulo 2^ADDR_W.
DATA_W, 8, ROM data width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous reset, active-high.
start  in  1  single-cycle scan request; accepted only in IDLE.
abort  in  1  terminates any scan; takes effect at the next edge.
start_addr  in  ADDR_W  first address; latched when start is accepted.
end_addr  in  ADDR_W  last address, inclusive; latched when start is accepted.
bank_sel  in  1  ROM bank, driven to the ROM b input; latched when start is accepted.
loop_mode  in  1  1 = restart at start_addr after end_addr; latched when start is accepted.
rom_addr  out  ADDR_W  to ROM a input.
rom_bank  out  1  to ROM b input.
rom_data  in  DATA_W  ROM c output, combinational from rom_addr/rom_bank.
out_data  out  DATA_W  registered ROM word.
out_valid  out  1  out_data holds a valid word.
out_ready  in  1  consumer accepts the word when out_valid && out_ready.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse when a one-shot scan completes.

Behaviour:
- Reset (async): state=IDLE. rom_addr, rom_bank, out_data, out_valid, busy and done are all 0. Latched config registers are cleared.
- States are IDLE, RUN and DRAIN.
- IDLE, start=1 and abort=0:
  - Latch start_addr, end_addr, bank_sel and loop_mode.
  - rom_addr <= start_addr, rom_bank <= bank_sel.
  - Go to RUN.
  - If abort=1 in the same cycle, abort wins and start is ignored.
- RUN, capture condition is (!out_valid || out_ready):
  - When true: out_data <= rom_data, out_valid <= 1.
  - If rom_addr != end_addr: rom_addr <= rom_addr+1, modulo 2^ADDR_W.
  - If rom_addr == end_addr and loop_mode=1: rom_addr <= start_addr and stay in RUN.
  - If rom_addr == end_addr and loop_mode=0: go to DRAIN and hold rom_addr.
- RUN, capture condition false:
  - Stall: rom_addr, out_data and out_valid hold.
  - A handshake clears out_valid only if no new capture happens in the same cycle.
- DRAIN:
  - When out_valid && out_ready, clear out_valid, pulse done for 1 cycle and go to IDLE.
  - If out_valid is already 0, do the same immediately.
- Latency:
  - start accepted at edge N → rom_addr=start_addr after N.
  - First word captured at edge N+1 (out_valid=1 with rom[start_addr]).
  - With out_ready held at 1, one word per cycle and no bubbles, including at loop wrap.
- Scan length = ((end_addr - start_addr) mod 2^ADDR_W) + 1.
  - end_addr < start_addr wraps through 0 (e.g. 0xFE→0x01 is 4 words).
  - start_addr == end_addr is a 1-word scan.
- Abort in RUN or DRAIN: at the next edge go to IDLE, out_valid <= 0, busy <= 0, done stays 0. The word in flight is discarded. rom_addr holds its last value.
- start while busy is ignored; the latched config does not change.
- Input changes to start_addr, end_addr, bank_sel and loop_mode after acceptance have no effect.
- out_data is only meaningful while out_valid=1; it is not cleared on handshake.
- busy is registered and equals (state != IDLE).

Test Plan:
The bench ROM model returns rom_data = rom_addr XOR {8{rom_bank}}.
1. Reset held 3 cycles, then released → all outputs 0, state IDLE. Asserting reset mid-RUN forces out_valid=0 and busy=0 asynchronously.
2. One-shot, start=0x10, end=0x13, bank=0, out_ready=1 → out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles. done pulses 1 cycle after the last handshake; busy then falls.
3. Wrap with bank=1, start=0xFE, end=0x01 → addresses FE,FF,00,01 give data 0x01,0x00,0xFF,0xFE, then done.
4. Backpressure: start=0x20, end=0x25, out_ready toggling 1,0,0,1,… → no word lost or duplicated, out_data stable while stalled, exactly 6 handshakes with data 0x20..0x25 in order.
5. Loop mode, start=0x05, end=0x07, out_ready=1 for 10 cycles → sequence 05,06,07,05,06,07,05,… with no gap. done is never asserted; abort then stops the scan, clears out_valid next cycle and returns to IDLE.
6. start pulsed in RUN with different addresses → ignored, the original scan completes unchanged. start and abort together in IDLE → stays IDLE with busy=0.
